// File: rtl/mem_resp_stage.sv
// mem_resp_stage: single-outstanding memory endpoint with a fixed wait-state
// latency, an internal word array and a tagged valid/ready response.
module mem_resp_stage #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ID_WIDTH-1:0]   req_id,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, next_state;
    logic [3:0]            cnt;
    logic                  write_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  accept;
    logic                  enter_done;
    logic                  acc_write;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    // NOTE: the array is deliberately left out of reset; its contents survive rst
    // and a reset branch here would also prevent mapping it onto RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Ready is gated by rst so nothing is accepted while the block is held in reset.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_id    = id_q;
    assign rsp_write = write_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

    // With zero wait states the access happens on the accept edge, so the
    // operands come straight from the request instead of the holding registers.
    assign acc_write = (state == IDLE) ? req_write : write_q;
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign in_range  = {1'b0, acc_addr} < DEPTH_LIM;
    assign idx       = acc_addr[IDX_W-1:0];

    // State register.
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and detection of the DONE-entry edge.
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        next_state = state;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        next_state = DONE;
                        enter_done = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request holding registers, captured on the request handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            id_q    <= req_id;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Wait-state counter: loaded on accept, counts down while in WAIT.
    always_ff @(posedge clk) begin
        if (rst)                 cnt <= 4'd0;
        else if (accept)         cnt <= WAIT_LOAD;
        else if (state == WAIT)  cnt <= cnt - 4'd1;
    end

    // Response registers, loaded once on entry to DONE and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (enter_done) begin
            err_q   <= !in_range;
            rdata_q <= (!acc_write && in_range) ? mem[idx] : '0;
        end
    end

    // Array write on DONE entry; a reset on that edge discards the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_done && acc_write && in_range) mem[idx] <= acc_wdata;
    end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Testbench for mem_resp_stage: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_mem_resp_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_id;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
    logic [3:0]  rsp_id;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [3:0]  z_req_id;
    logic [7:0]  z_req_addr;
    logic [31:0] z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_write, z_rsp_err, z_busy;
    logic [3:0]  z_rsp_id;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem   [256];
    bit          ref_known [256];

    always #5 clk = ~clk;

    mem_resp_stage #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_id(req_id), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .busy(busy)
    );

    mem_resp_stage #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_id(z_req_id), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_id(z_rsp_id),
        .rsp_write(z_rsp_write), .rsp_err(z_rsp_err), .rsp_rdata(z_rsp_rdata),
        .busy(z_busy)
    );

    // Model update for a completed access; returns expected err / rdata.
    task automatic model_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                                output logic e_err, output logic [31:0] e_rd, output bit e_known);
        e_err   = (int'(a) >= 200);
        e_rd    = 32'h0;
        e_known = 1'b1;
        if (!e_err) begin
            if (w) begin
                ref_mem[a]   = d;
                ref_known[a] = 1'b1;
            end else begin
                e_rd    = ref_mem[a];
                e_known = ref_known[a];
            end
        end
    endtask

    // Present a request and hold it until accepted; returns at the negedge after the handshake.
    task automatic send_req(input logic w, input logic [3:0] id, input logic [7:0] a,
                            input logic [31:0] d, output bit ok);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w; req_id = id; req_addr = a; req_wdata = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count cycles since the handshake until rsp_valid; -1 on timeout.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic end_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [3:0] id, input logic [7:0] a, input logic [31:0] d,
                       output logic [3:0] o_id, output logic o_w, output logic o_err,
                       output logic [31:0] o_rd, output int lat);
        bit ok;
        send_req(w, id, a, d, ok);
        if (!ok) lat = -1;
        else     wait_rsp(lat);
        o_id = rsp_id; o_w = rsp_write; o_err = rsp_err; o_rd = rsp_rdata;
        if (lat > 0) end_rsp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", req_ready); end
        checks++; if (z_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_w0: got %b expected 1", z_req_ready); end
        checks++; if ({rsp_err, rsp_write, rsp_id, rsp_rdata} !== 38'h0)
            begin errors++; $display("FAIL reset_outputs: got err=%b w=%b id=%h rd=%h expected all 0", rsp_err, rsp_write, rsp_id, rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [3:0] id; logic w, e; logic [31:0] rd; int lat;
        logic ee; logic [31:0] erd; bit kn;
        txn(1'b1, 4'd3, 8'h10, 32'hDEADBEEF, id, w, e, rd, lat);
        model_access(1'b1, 8'h10, 32'hDEADBEEF, ee, erd, kn);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
        checks++; if ({id, w, e, rd} !== {4'd3, 1'b1, 1'b0, 32'h0})
            begin errors++; $display("FAIL wr_response: got id=%h w=%b err=%b rd=%h expected id=3 w=1 err=0 rd=0", id, w, e, rd); end
        txn(1'b0, 4'd8, 8'h10, 32'h0, id, w, e, rd, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_after_wr: got %h expected deadbeef", rd); end
        checks++; if ({id, w, e} !== {4'd8, 1'b0, 1'b0}) begin errors++; $display("FAIL rd_fields: got id=%h w=%b err=%b expected id=8 w=0 err=0", id, w, e); end
    endtask

    task automatic test_backpressure();
        bit ok; int lat;
        send_req(1'b0, 4'd6, 8'h10, 32'h0, ok);
        wait_rsp(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", lat); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({rsp_valid, req_ready, busy} !== 3'b101)
                begin errors++; $display("FAIL bp_hold_ctrl: cycle %0d got valid/ready/busy=%b expected 101", i, {rsp_valid, req_ready, busy}); end
            checks++; if ({rsp_id, rsp_rdata} !== {4'd6, ref_mem[8'h10]})
                begin errors++; $display("FAIL bp_hold_data: cycle %0d got id=%h rd=%h expected id=6 rd=%h", i, rsp_id, rsp_rdata, ref_mem[8'h10]); end
            @(negedge clk);
        end
        end_rsp();
        checks++; if ({rsp_valid, req_ready, busy} !== 3'b010)
            begin errors++; $display("FAIL bp_release: got valid/ready/busy=%b expected 010", {rsp_valid, req_ready, busy}); end
    endtask

    task automatic test_bounds();
        logic [3:0] id; logic w, e; logic [31:0] rd; int lat;
        logic ee; logic [31:0] erd; bit kn;
        txn(1'b1, 4'd1, 8'd199, 32'h0BAD_C0DE, id, w, e, rd, lat);
        model_access(1'b1, 8'd199, 32'h0BAD_C0DE, ee, erd, kn);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL bnd_last_valid: got err=%b expected 0", e); end
        txn(1'b1, 4'd2, 8'd200, 32'hFFFF_FFFF, id, w, e, rd, lat);
        checks++; if ({e, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL bnd_wr_err: got err=%b rd=%h expected err=1 rd=0", e, rd); end
        txn(1'b0, 4'd3, 8'd199, 32'h0, id, w, e, rd, lat);
        checks++; if ({e, rd} !== {1'b0, 32'h0BAD_C0DE}) begin errors++; $display("FAIL bnd_rd_199: got err=%b rd=%h expected err=0 rd=0badc0de", e, rd); end
        txn(1'b0, 4'd4, 8'd255, 32'h0, id, w, e, rd, lat);
        checks++; if ({e, rd, id} !== {1'b1, 32'h0, 4'd4}) begin errors++; $display("FAIL bnd_rd_err: got err=%b rd=%h id=%h expected err=1 rd=0 id=4", e, rd, id); end
    endtask

    task automatic test_reset_mid_txn();
        logic [3:0] id; logic w, e; logic [31:0] rd; int lat;
        logic ee; logic [31:0] erd; bit kn; bit ok; bit seen;
        txn(1'b1, 4'd7, 8'd5, 32'hA5A5_0005, id, w, e, rd, lat);
        model_access(1'b1, 8'd5, 32'hA5A5_0005, ee, erd, kn);
        // Reset during WAIT: write must be discarded.
        send_req(1'b1, 4'd9, 8'd5, 32'h0000_1234, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_valid: got rsp_valid rise=%b expected 0", seen); end
        txn(1'b0, 4'd1, 8'd5, 32'h0, id, w, e, rd, lat);
        checks++; if (rd !== 32'hA5A5_0005) begin errors++; $display("FAIL rst_wait_discard: got %h expected a5a50005", rd); end
        // Reset during DONE: committed write stays.
        send_req(1'b1, 4'd2, 8'd6, 32'h0000_0077, ok);
        model_access(1'b1, 8'd6, 32'h0000_0077, ee, erd, kn);
        wait_rsp(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rst_done_latency: got %0d expected 3", lat); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_done_drop: got valid/busy=%b expected 00", {rsp_valid, busy}); end
        rst = 1'b0;
        txn(1'b0, 4'd3, 8'd6, 32'h0, id, w, e, rd, lat);
        checks++; if (rd !== 32'h0000_0077) begin errors++; $display("FAIL rst_done_kept: got %h expected 00000077", rd); end
    endtask

    task automatic test_req_during_done();
        logic [3:0] id; logic w, e; logic [31:0] rd; int lat;
        logic ee; logic [31:0] erd; bit kn; bit ok;
        send_req(1'b0, 4'd2, 8'h10, 32'h0, ok);
        wait_rsp(lat);
        req_valid = 1'b1; req_write = 1'b1; req_id = 4'd4; req_addr = 8'h20; req_wdata = 32'h2020_C0C0;
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL done_no_accept: got ready=%b expected 0", req_ready); end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, req_ready, busy} !== 3'b010)
            begin errors++; $display("FAIL done_then_idle: got valid/ready/busy=%b expected 010", {rsp_valid, req_ready, busy}); end
        @(negedge clk);
        req_valid = 1'b0;
        model_access(1'b1, 8'h20, 32'h2020_C0C0, ee, erd, kn);
        checks++; if ({busy, req_ready} !== 2'b10) begin errors++; $display("FAIL idle_accept: got busy/ready=%b expected 10", {busy, req_ready}); end
        wait_rsp(lat);
        checks++; if ({lat, rsp_id} !== {32'd3, 4'd4}) begin errors++; $display("FAIL second_rsp: got lat=%0d id=%h expected lat=3 id=4", lat, rsp_id); end
        end_rsp();
        txn(1'b0, 4'd5, 8'h20, 32'h0, id, w, e, rd, lat);
        checks++; if (rd !== 32'h2020_C0C0) begin errors++; $display("FAIL second_committed: got %h expected 2020c0c0", rd); end
    endtask

    task automatic test_random();
        logic [3:0] id, eid; logic w, e, ew; logic [31:0] rd, d; logic [7:0] a; int lat, hold;
        logic ee; logic [31:0] erd; bit kn; bit ok;
        for (int n = 0; n < 40; n++) begin
            ew   = 1'($urandom_range(0, 1));
            eid  = 4'($urandom);
            a    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(195, 210)) : 8'($urandom_range(0, 15));
            d    = $urandom;
            hold = $urandom_range(0, 2);
            send_req(ew, eid, a, d, ok);
            if (!ok) lat = -1;
            else     wait_rsp(lat);
            repeat (hold) @(negedge clk);
            id = rsp_id; w = rsp_write; e = rsp_err; rd = rsp_rdata;
            if (lat > 0) end_rsp();
            model_access(ew, a, d, ee, erd, kn);
            checks++; if (lat !== 3) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected 3", n, lat); end
            checks++; if ({id, w, e} !== {eid, ew, ee})
                begin errors++; $display("FAIL rnd_fields[%0d]: got id=%h w=%b err=%b expected id=%h w=%b err=%b", n, id, w, e, eid, ew, ee); end
            if (kn) begin
                checks++; if (rd !== erd) begin errors++; $display("FAIL rnd_rdata[%0d] addr=%0d: got %h expected %h", n, a, rd, erd); end
            end
        end
    endtask

    task automatic test_back_to_back_w0();
        logic [31:0] z_mem [4];
        int cyc, acc, prev, n;
        cyc = 0; prev = 0;
        z_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            z_req_valid = 1'b1;
            z_req_write = (i < 4);
            z_req_id    = 4'(i);
            z_req_addr  = 8'(40 + (i % 4));
            z_req_wdata = 32'hC000_0000 + 32'(i * 17);
            n = 0;
            while (!z_req_ready && n < 20) begin
                @(negedge clk);
                cyc++; n++;
            end
            acc = cyc;
            if (i > 0) begin
                checks++; if (acc - prev !== 2) begin errors++; $display("FAIL w0_spacing[%0d]: got %0d expected 2", i, acc - prev); end
            end
            prev = acc;
            if (i < 4) z_mem[i] = z_req_wdata;
            @(negedge clk);
            cyc++;
            checks++; if ({z_rsp_valid, z_rsp_id, z_rsp_write} !== {1'b1, 4'(i), (i < 4)})
                begin errors++; $display("FAIL w0_rsp[%0d]: got valid=%b id=%h w=%b expected valid=1 id=%h w=%b", i, z_rsp_valid, z_rsp_id, z_rsp_write, 4'(i), (i < 4)); end
            if (i >= 4) begin
                checks++; if (z_rsp_rdata !== z_mem[i - 4]) begin errors++; $display("FAIL w0_rdata[%0d]: got %h expected %h", i, z_rsp_rdata, z_mem[i - 4]); end
            end
        end
        z_req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_id = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_id = '0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = 32'h0;
            ref_known[i] = 1'b0;
        end
        test_reset();
        test_write_read();
        test_backpressure();
        test_bounds();
        test_reset_mid_txn();
        test_req_during_done();
        test_random();
        test_back_to_back_w0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
